// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop.
// Define UART_TX_STOP2_EN to transmit two stop bits instead of one.
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_PAR   = 2'b10;
    localparam logic [1:0] SEL_STOP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic [1:0]            r_mux_sel;
    logic                  r_busy;
`ifdef UART_TX_STOP2_EN
    logic                  r_stop_cnt;
`endif

    function automatic logic f_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_mux_sel  <= SEL_STOP;
            r_busy     <= 1'b0;
`ifdef UART_TX_STOP2_EN
            r_stop_cnt <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (DATA_VALID) begin
                        r_shreg   <= P_DATA;
                        r_par_en  <= PAR_EN;
                        r_par_bit <= f_parity(P_DATA, PAR_TYP);
                        r_state   <= S_START;
                        r_mux_sel <= SEL_START;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    r_cnt     <= '0;
                    r_state   <= S_DATA;
                    r_mux_sel <= SEL_DATA;
                end
                S_DATA: begin
                    // Shift at the end of each data cycle so bit 0 is always the bit on show.
                    r_shreg <= r_shreg >> 1;
                    if (r_cnt == LAST_BIT) begin
                        if (r_par_en) begin
                            r_state   <= S_PARITY;
                            r_mux_sel <= SEL_PAR;
                        end else begin
                            r_state   <= S_STOP;
                            r_mux_sel <= SEL_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    r_state   <= S_STOP;
                    r_mux_sel <= SEL_STOP;
`ifdef UART_TX_STOP2_EN
                    r_stop_cnt <= 1'b0;
`endif
                end
                S_STOP: begin
`ifdef UART_TX_STOP2_EN
                    if (!r_stop_cnt) begin
                        r_stop_cnt <= 1'b1;
                    end else begin
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                    end
`else
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`endif
                    r_mux_sel <= SEL_STOP;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mux_sel <= SEL_STOP;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mux_sel  = r_mux_sel;
    assign ser_data = r_shreg[0];
    assign par_bit  = r_par_bit;
    assign busy     = r_busy;

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame sequencer for the UART transmitter. Accepts a parallel byte with a valid strobe and walks the transmit path through start, data, optional parity and stop phases. It shifts the data LSB-first, computes the parity bit and drives the 2-bit select of the registered TX output mux. It sits between the host-side data interface and the TX mux; one transmitted bit per CLK cycle (CLK is the baud-rate clock).

## Interface
- DATA_WIDTH, 8, payload bits per frame (≥ 1)
- CLK  input  1  baud-rate clock, all state on rising edge
- RST  input  1  asynchronous, active-high reset
- P_DATA  input  DATA_WIDTH  parallel payload, sampled on acceptance only
- DATA_VALID  input  1  request to send P_DATA
- PAR_EN  input  1  1 = parity bit inserted; sampled on acceptance
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
- mux_sel  output  2  TX mux select: 00 start, 01 data, 10 parity, 11 stop/idle
- ser_data  output  1  current data bit (shift register bit 0)
- par_bit  output  1  registered parity bit of the latched payload
- busy  output  1  frame in progress; DATA_VALID ignored while high

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding is implementer's choice. mux_sel is a registered decode of the state: IDLE/STOP→11, START→00, DATA→01, PARITY→10.
- Acceptance: DATA_VALID=1 while in IDLE. On that edge, latch P_DATA into the shift register and latch PAR_EN. Set par_bit = ^P_DATA (even) or ~^P_DATA (odd). Next state is START.
- START: 1 cycle → DATA. The bit counter is cleared.
- DATA: DATA_WIDTH cycles. ser_data = shreg[0]. Each cycle the register shifts right (fill 0) and the counter increments. On count = DATA_WIDTH-1 the next state is PARITY if latched PAR_EN=1, otherwise STOP.
- PARITY: 1 cycle → STOP.
- STOP: 1 cycle (2 with macro, see Configuration) → IDLE.
- busy = 1 in START, DATA, PARITY and STOP, and 0 in IDLE. It is registered together with the state.
- No back-to-back: after STOP the FSM always spends ≥ 1 cycle in IDLE. A DATA_VALID during STOP is dropped. The requester must hold or re-assert it.
- P_DATA, PAR_EN and PAR_TYP changing mid-frame have no effect on the frame in progress.
- Counter width is $clog2(DATA_WIDTH), minimum 1. There is no wrap beyond DATA_WIDTH-1.

## Timing
- Reset values (asynchronous, immediate): state IDLE, mux_sel=11, busy=0, ser_data=0, par_bit=0, shreg=0, counter=0.
- Reset mid-frame aborts the frame. mux_sel=11 the same instant, so the mux drives a stop/idle level from its next edge.
- Acceptance edge E0: busy=1 and mux_sel=00 visible after E0. The first data bit is selected after E0+1.
- Frame length in busy cycles: DATA_WIDTH+3 with parity, DATA_WIDTH+2 without (+1 with the macro).
- The downstream mux registers its output, so the line lags mux_sel/ser_data by exactly 1 cycle. The controller does not compensate.
- ser_data and par_bit are stable for the whole cycle in which their mux_sel code is presented.

## Configuration
- UART_TX_STOP2_EN
  - Defined: STOP lasts 2 cycles (two stop bits); a 1-bit stop counter is added; busy is held through both.
  - Undefined: STOP lasts 1 cycle, and no extra logic is present.

## Test plan
- Reset then idle: RST=1 mid-DATA of a frame → mux_sel=11, busy=0 immediately. After release, with DATA_VALID=0 for 20 cycles, mux_sel stays 11.
- Even parity, DATA_WIDTH=8:
  - Stimulus: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID.
  - mux_sel sequence: 00, 01×8, 10, 11. ser_data during 01: 1,0,1,0,0,1,0,1. par_bit=0. busy high 11 cycles.
- Odd parity:
  - Stimulus: P_DATA=0x01, PAR_TYP=1.
  - par_bit=0. The line carries 0,1,0,0,0,0,0,0,0,0,1.
- No parity:
  - Stimulus: P_DATA=0xFF, PAR_EN=0.
  - mux_sel goes 00, 01×8, 11 with no 10. busy high 10 cycles.
- DATA_VALID held high continuously with P_DATA=0x3C:
  - Frames repeat with exactly 1 IDLE cycle (mux_sel=11, busy=0) between them.
  - Changing P_DATA mid-frame does not alter the current frame's bits.
- UART_TX_STOP2_EN defined, 0xA5 even parity: identical to the even-parity scenario except mux_sel=11 with busy=1 for 2 cycles; busy high 12 cycles.
